sbus_rd_arbiter: RTL and testbench
==================================

# sbus_rd_arbiter

- Shares the single AXI4 read address/data channel between the instruction-fetch requester (I) and the data-load requester (D).
- Sits between the core's two bus masters and the AXI bridge. It owns arid/araddr/arlen/arsize/arburst/arvalid and rready.
- Serves one outstanding read burst at a time and arbitrates round-robin.
- Routes returning beats to the owner and checks burst length and response codes.

## Interface
Parameters:
- ID_I, 4'd0, arid driven for I bursts
- ID_D, 4'd1, arid driven for D bursts
- I_SIZE, 3'b010, arsize for I bursts (4-byte beats)

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- i_req  in  1  I requests a read burst; held with i_addr/i_len until i_gnt
- i_addr  in  32  I burst start address
- i_len  in  8  I beats minus one
- i_gnt  out  1  pulse: I burst address accepted by AXI
- i_rvalid  out  1  beat for I valid
- i_rdata  out  32  beat data
- i_rlast  out  1  final beat of I burst
- i_err  out  1  with i_rlast: burst failed (rresp≠0, length or id mismatch)
- d_req, d_addr(32), d_len(8), d_size(3)  in  D request; same rules as I, with d_size giving arsize
- d_gnt, d_rvalid, d_rdata(32), d_rlast, d_err  out  as for I
- arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1  out  AXI read address channel
- arready  in  1
- rid 4, rdata 32, rresp 2, rlast 1, rvalid 1  in  AXI read data channel
- rready  out  1

## Operation
- States: IDLE, ADDR, DATA.
- **IDLE**
  - If any req is high, choose an owner.
    - Only one requester high: that requester wins.
    - Both high: the requester not served last wins. The last-served pointer resets to I, so D wins the first tie.
  - Register the owner's addr, len and size (I_SIZE for I), then go to ADDR.
- **ADDR**
  - arvalid=1, driven from registers: arid per owner, arburst=2'b01 (INCR), arlock/arcache/arprot = 0.
  - arvalid stays high until arready. Address fields stay stable throughout.
  - On arvalid&arready:
    - pulse owner's *_gnt (combinational, same cycle);
    - load beat counter with the registered len;
    - update the last-served pointer;
    - go to DATA.
- **DATA**
  - rready=1. Each rvalid beat is forwarded combinationally to the owner only: *_rvalid, *_rdata=rdata, *_rlast=rlast.
  - The counter decrements per beat.
  - Error is sticky for the burst and is reported with the terminating beat. It is set by any of:
    - rresp≠0;
    - rid≠owner id;
    - rlast before the counter reaches 0;
    - counter at 0 without rlast.
  - A burst terminates on the beat with rlast=1 or the beat where the counter was 0, whichever comes first.
    - The owner's *_rlast=1 on that beat, even if the bus lacked rlast.
    - Go to IDLE.
  - Beats arriving after an early termination are accepted (rready stays 1 in IDLE) and dropped.
- Owner dropping req after capture is ignored. The burst completes and beats are still delivered.
- The non-owner's outputs stay 0 at all times.
- Reset (asynchronous, at any state):
  - state=IDLE, pointer=I, counter=0;
  - arvalid=0, rready=0, all *_gnt/*_rvalid/*_rlast/*_err = 0, address registers 0.
  - An in-flight AXI transaction is abandoned; the interconnect is reset together with the core.

## Timing
- req high at edge N (IDLE) → arvalid high in cycle N+1.
- gnt coincides with the arvalid&arready cycle. The first beat may arrive in the following cycle at the earliest.
- Beat forwarding has zero latency: rvalid → *_rvalid in the same cycle.
- After the terminating beat, one IDLE cycle follows before the next arvalid. Minimum request-to-request gap is 2 cycles.
- rready is 1 in DATA and IDLE and 0 in ADDR. A pipelined slave may not drive beats before the handshake.
- Single outstanding burst. The next AR is never issued before the previous burst terminates.

## Test plan
- **Single I read:** i_req, i_addr=0xBFC00000, i_len=0, arready=1 at once.
  - arvalid in cycle 1 with arid=0, arsize=2, arlen=0; i_gnt in cycle 1.
  - Beat rdata=0x3C08BFC0, rlast=1 → i_rvalid/i_rlast with that data, i_err=0; d_* stay 0.
- **Simultaneous requests after reset:** i_req and d_req high together.
  - D is served first (arid=1, arlen=d_len, arsize=d_size); I is served after D's terminating beat.
  - Repeat both high: grants alternate I, D, I.
- **8-beat D burst with arready delayed 3 cycles:**
  - arvalid and araddr stay stable for 4 cycles; d_gnt fires once.
  - 8 beats reach the D port; d_rlast only on the 8th.
- **Errors:**
  - rresp=2'b10 on beat 2 of a 4-beat burst → d_err=1 on beat 4.
  - rlast on beat 2 of arlen=3 → d_rlast and d_err on beat 2, then return to IDLE.
- **Reset mid-burst:** resetn low during beat 2 of a 4-beat burst.
  - All outputs 0 asynchronously.
  - After release, a new i_req issues a fresh AR and the I-first pointer behaviour holds.

Source files
------------

// File: rtl/sbus_rd_arbiter.sv
// rtl/sbus_rd_arbiter.sv - round-robin arbiter sharing one AXI4 read channel between I-fetch and D-load
// One burst in flight at a time; beats are steered to the owner and checked for length, id and response.
module sbus_rd_arbiter #(
  parameter logic [3:0] ID_I   = 4'd0,
  parameter logic [3:0] ID_D   = 4'd1,
  parameter logic [2:0] I_SIZE = 3'b010
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [7:0]  d_len,
  input  logic [2:0]  d_size,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = D owns the current burst
  logic        last_q, last_d;     // 1 = D was served last
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        pick_d;
  logic        term;
  logic        beat_err;
  logic [3:0]  owner_id;
  logic        fwd_i, fwd_d;

  // On a tie the requester not served last wins.
  assign pick_d   = d_req && (!i_req || !last_q);
  assign owner_id = owner_q ? ID_D : ID_I;
  assign term     = rlast || (cnt_q == 8'd0);
  assign beat_err = (rresp != 2'b00) || (rid != owner_id) ||
                    (rlast && (cnt_q != 8'd0)) || (!rlast && (cnt_q == 8'd0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          owner_d = pick_d;
          addr_d  = pick_d ? d_addr : i_addr;
          len_d   = pick_d ? d_len : i_len;
          size_d  = pick_d ? d_size : I_SIZE;
          err_d   = 1'b0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arready) begin
          cnt_d   = len_q;
          last_d  = owner_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rvalid) begin
          if (term) begin
            err_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
            err_d = err_q || beat_err;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    arvalid  = (state_q == ST_ADDR);
    arid     = owner_id;
    araddr   = addr_q;
    arlen    = len_q;
    arsize   = size_q;
    arburst  = arvalid ? 2'b01 : 2'b00;
    arlock   = 2'b00;
    arcache  = 4'b0000;
    arprot   = 3'b000;
    // Late beats after an early termination are drained in IDLE.
    rready   = resetn && (state_q != ST_ADDR);
    i_gnt    = arvalid && arready && !owner_q;
    d_gnt    = arvalid && arready && owner_q;
    fwd_i    = (state_q == ST_DATA) && rvalid && !owner_q;
    fwd_d    = (state_q == ST_DATA) && rvalid && owner_q;
    i_rvalid = fwd_i;
    i_rdata  = fwd_i ? rdata : 32'h0;
    i_rlast  = fwd_i && term;
    i_err    = fwd_i && term && (err_q || beat_err);
    d_rvalid = fwd_d;
    d_rdata  = fwd_d ? rdata : 32'h0;
    d_rlast  = fwd_d && term;
    d_err    = fwd_d && term && (err_q || beat_err);
  end

endmodule

// File: tb/tb_sbus_rd_arbiter.sv
// tb/tb_sbus_rd_arbiter.sv - self-checking bench for sbus_rd_arbiter
module tb_sbus_rd_arbiter;

  localparam logic [3:0] ID_I = 4'd0;
  localparam logic [3:0] ID_D = 4'd1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic [7:0]  i_len, d_len;
  logic [2:0]  d_size;
  logic        i_gnt, i_rvalid, i_rlast, i_err;
  logic        d_gnt, d_rvalid, d_rlast, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic [3:0]  arid, arcache;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  sbus_rd_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_err(d_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    bit          i_on, d_on, own_d, drop_early, no_last, bad_id;
    logic [31:0] i_addr, d_addr, dbase;
    logic [7:0]  i_len, d_len;
    logic [2:0]  d_size;
    int          ar_delay, bad_beat, early_last, rst_at;
  } vec_t;

  typedef struct {
    bit          own_d;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  typedef struct {
    bit          own_d;
    logic [31:0] data;
    bit          last;
    bit          err;
  } beat_t;

  vec_t  vecs[14];
  ar_t   ar_q[$];
  beat_t beat_q[$];
  ar_t   ea;
  beat_t eb;
  int    checks = 0;
  int    errors = 0;
  int    gnt_seen = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard side: address handshakes and forwarded beats are checked against queued expectations.
  always @(negedge clk) begin
    if (resetn) begin
      if (i_gnt || d_gnt) gnt_seen++;
      if (arvalid && arready) begin
        if (ar_q.size() == 0) begin
          chk("ar_unexpected", 64'(arvalid), 64'(0));
        end else begin
          ea = ar_q.pop_front();
          chk("arid", 64'(arid), 64'(ea.own_d ? ID_D : ID_I));
          chk("araddr", 64'(araddr), 64'(ea.addr));
          chk("arlen", 64'(arlen), 64'(ea.len));
          chk("arsize", 64'(arsize), 64'(ea.size));
          chk("arburst_attr", 64'({arburst, arlock, arcache, arprot}), 64'({2'b01, 9'd0}));
          chk("gnt_owner", 64'({i_gnt, d_gnt}), 64'(ea.own_d ? 2'b01 : 2'b10));
        end
      end else begin
        chk("gnt_idle", 64'({i_gnt, d_gnt}), 64'(0));
      end
      if (i_rvalid || d_rvalid) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 64'({i_rvalid, d_rvalid}), 64'(0));
        end else begin
          eb = beat_q.pop_front();
          chk("beat_port", 64'({i_rvalid, d_rvalid}), 64'(eb.own_d ? 2'b01 : 2'b10));
          chk("beat_data", 64'(eb.own_d ? d_rdata : i_rdata), 64'(eb.data));
          chk("beat_last", 64'(eb.own_d ? d_rlast : i_rlast), 64'(eb.last));
          chk("beat_err", 64'(eb.own_d ? d_err : i_err), 64'(eb.err));
          chk("nonowner_zero", 64'(eb.own_d ? {i_rlast, i_err, |i_rdata} : {d_rlast, d_err, |d_rdata}), 64'(0));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    logic [3:0]  exp_id;
    logic [3:0]  id;
    logic [1:0]  rsp;
    logic        lst;
    int          el, nb, g0;
    bit          err_acc, done, term;
    ar_t         at;
    beat_t       bt;
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
    i_req = v.i_on; i_addr = v.i_addr; i_len = v.i_len;
    d_req = v.d_on; d_addr = v.d_addr; d_len = v.d_len; d_size = v.d_size;
    exp_addr = v.own_d ? v.d_addr : v.i_addr;
    exp_len  = v.own_d ? v.d_len : v.i_len;
    exp_id   = v.own_d ? ID_D : ID_I;
    el       = int'(exp_len);
    at.own_d = v.own_d; at.addr = exp_addr; at.len = exp_len;
    at.size  = v.own_d ? v.d_size : 3'b010;
    ar_q.push_back(at);
    g0 = gnt_seen;
    @(negedge clk);
    chk("ar_not_early", 64'(arvalid), 64'(0));
    for (int k = 0; k <= v.ar_delay; k++) begin
      @(posedge clk); #1;
      if (k == 0 && v.drop_early) begin i_req = 1'b0; d_req = 1'b0; end
      if (k == v.ar_delay) arready = 1'b1;
      @(negedge clk);
      chk("ar_valid_hold", 64'(arvalid), 64'(1));
      chk("ar_addr_hold", 64'(araddr), 64'(exp_addr));
      chk("rready_in_addr", 64'(rready), 64'(0));
    end
    @(posedge clk); #1;
    arready = 1'b0; i_req = 1'b0; d_req = 1'b0;
    chk("gnt_once", 64'(gnt_seen - g0), 64'(1));
    nb = (v.early_last >= 0) ? v.early_last + 3 : el + 1;
    err_acc = 1'b0;
    done = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (b > 0) begin @(posedge clk); #1; end
      lst = (v.early_last >= 0) ? (b == v.early_last) : (!v.no_last && b == el);
      rsp = (b == v.bad_beat) ? 2'b10 : 2'b00;
      id  = (v.bad_id && b == 0) ? (v.own_d ? ID_I : ID_D) : exp_id;
      rvalid = 1'b1; rdata = v.dbase + 32'(b); rlast = lst; rresp = rsp; rid = id;
      if (b == v.rst_at) begin
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_outputs", 64'({arvalid, rready, i_gnt, d_gnt, i_rvalid, d_rvalid,
            i_rlast, d_rlast, i_err, d_err, |i_rdata, |d_rdata}), 64'(0));
        chk("rst_addr_regs", 64'({araddr, arlen}), 64'(0));
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        break;
      end
      if (!done) begin
        term = lst || (b == el);
        err_acc = err_acc || (rsp != 2'b00) || (id != exp_id) || (lst && b != el) || (!lst && b == el);
        bt.own_d = v.own_d; bt.data = v.dbase + 32'(b); bt.last = term; bt.err = term && err_acc;
        beat_q.push_back(bt);
        if (term) done = 1'b1;
      end
      @(negedge clk);
      chk("rready_in_data", 64'(rready), 64'(1));
    end
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    chk("beats_drained", 64'(beat_q.size()), 64'(0));
    chk("ar_drained", 64'(ar_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    // fields: i_on d_on own_d drop_early no_last bad_id i_addr d_addr dbase i_len d_len d_size ar_delay bad_beat early_last rst_at
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 32'hBFC0_0000, 32'h0, 32'h3C08_BFC0, 8'd0, 8'd0, 3'd0, 0, -1, -1, -1};
    vecs[1]  = '{1, 1, 1, 0, 0, 0, 32'h0000_1000, 32'h0000_2000, 32'hD000_0000, 8'd1, 8'd2, 3'd0, 0, -1, -1, -1};
    vecs[2]  = '{1, 1, 0, 0, 0, 0, 32'h0000_1100, 32'h0000_2100, 32'h1000_0000, 8'd3, 8'd0, 3'd1, 1, -1, -1, -1};
    vecs[3]  = '{1, 1, 1, 0, 0, 0, 32'h0000_1200, 32'h0000_2200, 32'hD100_0000, 8'd0, 8'd1, 3'd2, 0, -1, -1, -1};
    vecs[4]  = '{1, 1, 0, 0, 0, 0, 32'h0000_1300, 32'h0000_2300, 32'h1100_0000, 8'd1, 8'd1, 3'd2, 0, -1, -1, -1};
    vecs[5]  = '{0, 1, 1, 0, 0, 0, 32'h0, 32'h8000_0040, 32'hD200_0000, 8'd0, 8'd7, 3'd2, 3, -1, -1, -1};
    vecs[6]  = '{0, 1, 1, 0, 0, 0, 32'h0, 32'h8000_0100, 32'hD300_0000, 8'd0, 8'd3, 3'd2, 0, 1, -1, -1};
    vecs[7]  = '{0, 1, 1, 0, 0, 0, 32'h0, 32'h8000_0180, 32'hD380_0000, 8'd0, 8'd3, 3'd2, 0, -1, 1, -1};
    vecs[8]  = '{1, 0, 0, 1, 1, 0, 32'h0040_0000, 32'h0, 32'h2000_0000, 8'd2, 8'd0, 3'd0, 2, -1, -1, -1};
    vecs[9]  = '{0, 1, 1, 0, 0, 1, 32'h0, 32'h8000_0200, 32'hD400_0000, 8'd0, 8'd1, 3'd2, 0, -1, -1, -1};
    vecs[10] = '{0, 1, 1, 0, 0, 0, 32'h0, 32'h8000_0300, 32'hD500_0000, 8'd0, 8'd3, 3'd2, 1, -1, -1, 1};
    vecs[11] = '{1, 1, 1, 0, 0, 0, 32'h0000_1400, 32'h0000_2400, 32'hD600_0000, 8'd0, 8'd0, 3'd2, 0, -1, -1, -1};
    vecs[12] = '{1, 0, 0, 0, 0, 0, 32'hBFC0_0010, 32'h0, 32'h3000_0000, 8'd0, 8'd0, 3'd0, 0, -1, -1, -1};
    vecs[13] = '{1, 1, 1, 0, 0, 0, 32'h0000_1500, 32'h0000_2500, 32'hD700_0000, 8'd1, 8'd2, 3'd1, 0, -1, -1, -1};

    resetn = 1'b0;
    i_req = 1'b0; i_addr = '0; i_len = '0;
    d_req = 1'b0; d_addr = '0; d_len = '0; d_size = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({arvalid, rready, i_gnt, d_gnt, i_rvalid, d_rvalid,
        i_rlast, d_rlast, i_err, d_err, |i_rdata, |d_rdata}), 64'(0));
    chk("reset_ar_fields", 64'({araddr, arlen, arsize}), 64'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rready_idle", 64'(rready), 64'(1));

    // Reset while an address phase is still waiting for arready.
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = 32'h1234_5678; d_len = 8'd4; d_size = 3'd1;
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    chk("ar_pending_valid", 64'(arvalid), 64'(1));
    chk("ar_pending_addr", 64'(araddr), 64'(32'h1234_5678));
    #1 resetn = 1'b0;
    #1;
    chk("rst_in_addr", 64'({arvalid, rready, d_gnt, araddr}), 64'(0));
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
